// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: state encoding,
// requester count, hold counter width and the rotating-priority helpers.
package rr_arbiter4_pkg;

    // Arbiter state encoding
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned HOLD_W  = 8;

    // Rotating-priority pick: the first set request bit searching
    // ptr+1, ptr+2, ptr+3, ptr (mod 4). Returns ptr when no bit is set;
    // callers only use the result when req is non-zero.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                pick  = pick;
                found = found;
            end
        end
        return pick;
    endfunction

    // One-hot encoding of a requester index
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter4_mux4x1.sv
// Shared-resource data mux: selects one of four requester data words.
module rr_arbiter4_mux4x1 #(
    parameter int unsigned data_width = 32
) (
    input  logic [data_width-1:0] a,
    input  logic [data_width-1:0] b,
    input  logic [data_width-1:0] c,
    input  logic [data_width-1:0] d,
    input  logic [1:0]            s,
    output logic [data_width-1:0] y
);

    // Pure 4:1 selection on s
    always_comb begin
        y = a;
        case (s)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            2'd3:    y = d;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter for a single shared resource.
// A grant is held until the resource reports done, the owner withdraws its
// request, or the owner has held the resource for hold_limit cycles. Every
// release goes through an IDLE cycle, and the released owner becomes the
// lowest priority for the next pick.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int unsigned data_width = 32,
    parameter int unsigned hold_limit = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req,
    input  logic                  done,
    input  logic [data_width-1:0] a,
    input  logic [data_width-1:0] b,
    input  logic [data_width-1:0] c,
    input  logic [data_width-1:0] d,
    output logic [3:0]            gnt,
    output logic [1:0]            sel,
    output logic [data_width-1:0] out,
    output logic                  busy,
    output logic                  timeout
);

    // Hold counter value on the owner's last permitted cycle
    localparam logic [HOLD_W-1:0] hold_last = HOLD_W'(hold_limit - 32'd1);
    localparam logic [HOLD_W-1:0] hold_max  = {HOLD_W{1'b1}};

    arb_state_e        state_r, state_s;
    logic [1:0]        ptr_r, ptr_s;
    logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
    logic [3:0]        gnt_r, gnt_s;
    logic [1:0]        sel_r, sel_s;
    logic              busy_r, busy_s;
    logic              timeout_r, timeout_s;

    logic [1:0]        pick_s;
    logic              owner_req_s;
    logic              hit_limit_s;
    logic              release_s;

    // Release qualifiers for the current owner (meaningful only in GRANT)
    always_comb begin
        pick_s      = rr_pick(req, ptr_r);
        owner_req_s = req[sel_r];
        hit_limit_s = (hold_cnt_r == hold_last);
        release_s   = done | ~owner_req_s | hit_limit_s;
    end

    // Next-state and next-output logic
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        hold_cnt_s = hold_cnt_r;
        gnt_s      = gnt_r;
        sel_s      = sel_r;
        busy_s     = busy_r;
        timeout_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // done is ignored here; sel keeps the last owner
                hold_cnt_s = {HOLD_W{1'b0}};
                if (req != 4'b0000) begin
                    state_s = ST_GRANT;
                    gnt_s   = onehot4(pick_s);
                    sel_s   = pick_s;
                    busy_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                    gnt_s   = 4'b0000;
                    busy_s  = 1'b0;
                end
            end

            ST_GRANT: begin
                if (release_s) begin
                    state_s    = ST_IDLE;
                    gnt_s      = 4'b0000;
                    busy_s     = 1'b0;
                    ptr_s      = sel_r;
                    hold_cnt_s = {HOLD_W{1'b0}};
                    // Only a pure hold-limit expiry is reported as a timeout
                    timeout_s  = hit_limit_s & ~done & owner_req_s;
                end else begin
                    state_s = ST_GRANT;
                    // Saturate rather than wrap
                    if (hold_cnt_r != hold_max) begin
                        hold_cnt_s = hold_cnt_r + 8'd1;
                    end else begin
                        hold_cnt_s = hold_cnt_r;
                    end
                end
            end

            default: begin
                state_s    = ST_IDLE;
                gnt_s      = 4'b0000;
                busy_s     = 1'b0;
                hold_cnt_s = {HOLD_W{1'b0}};
            end
        endcase
    end

    // State and registered outputs; reset leaves requester 0 first in line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            ptr_r      <= 2'd3;
            hold_cnt_r <= {HOLD_W{1'b0}};
            gnt_r      <= 4'b0000;
            sel_r      <= 2'd0;
            busy_r     <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            ptr_r      <= ptr_s;
            hold_cnt_r <= hold_cnt_s;
            gnt_r      <= gnt_s;
            sel_r      <= sel_s;
            busy_r     <= busy_s;
            timeout_r  <= timeout_s;
        end
    end

    assign gnt     = gnt_r;
    assign sel     = sel_r;
    assign busy    = busy_r;
    assign timeout = timeout_r;

    // Shared data path
    rr_arbiter4_mux4x1 #(
        .data_width(data_width)
    ) u_mux (
        .a(a),
        .b(b),
        .c(c),
        .d(d),
        .s(sel_r),
        .y(out)
    );

endmodule
